// File: rtl/clz_arbiter.sv
// clz_arbiter: round-robin arbiter sharing one leading-zero counter among
// NREQ valid/ready requesters through a two-stage pipeline (capture, count).
// Optional feature macro: CLZ_ARBITER_STATS_EN adds the stat_stall counter port.

// Combinational leading-zero counter; zero flags an all-zero operand.
module clz #(
  parameter int bits_in = 32,
  localparam int bits_out = $clog2(bits_in)
) (
  input  logic [bits_in-1:0]  data,
  output logic [bits_out-1:0] count,
  output logic                zero
);

  // Scan from the MSB down; the first set bit fixes the count.
  always_comb begin
    logic found;
    found = 1'b0;
    count = '0;
    zero  = ~|data;
    for (int i = bits_in - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        found = 1'b1;
        count = bits_out'(bits_in - 1 - i);
      end
    end
  end

endmodule

module clz_arbiter #(
  parameter int NREQ    = 4,
  parameter int BITS_IN = 32,
  localparam int BITS_OUT = $clog2(BITS_IN),
  localparam int ID_W     = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*BITS_IN-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [BITS_OUT-1:0]     rsp_count,
  output logic                    rsp_zero
`ifdef CLZ_ARBITER_STATS_EN
  ,
  output logic [15:0]             stat_stall
`endif
);

  logic [BITS_IN-1:0]  operand [NREQ];
  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     grant_id;
  logic [BITS_IN-1:0]  sel_data;
  logic                xfer;
  logic                s1_adv;
  logic                s2_adv;

  logic                s1_valid_reg;
  logic [BITS_IN-1:0]  s1_data_reg;
  logic [ID_W-1:0]     s1_id_reg;
  logic [ID_W-1:0]     last_reg;

  logic [BITS_OUT-1:0] clz_count;
  logic                clz_zero;

  // Unpack the flat operand bus into per-requester words.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign operand[gi] = req_data[gi*BITS_IN +: BITS_IN];
    end
  endgenerate

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid_reg || s2_adv;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    grant    = '0;
    grant_id = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_reg) + off) % NREQ;
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Ready only when S1 can take a word; suppressed while reset is held.
  assign req_ready = (s1_adv && !rst) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);

  // Operand mux driven by the grant so req_ready never depends on data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_data = operand[i];
    end
  end

  // Stage S1: capture the granted operand and advance the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_id_reg    <= '0;
      last_reg     <= ID_W'(NREQ - 1);
    end else if (s1_adv) begin
      s1_valid_reg <= xfer;
      if (xfer) begin
        s1_data_reg <= sel_data;
        s1_id_reg   <= grant_id;
        last_reg    <= grant_id;
      end
    end
  end

  clz #(.bits_in(BITS_IN)) u_clz (
    .data  (s1_data_reg),
    .count (clz_count),
    .zero  (clz_zero)
  );

  // Stage S2: register the count; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= '0;
      rsp_zero  <= 1'b0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid_reg;
      rsp_id    <= s1_id_reg;
      rsp_zero  <= clz_zero;
      rsp_count <= clz_zero ? '0 : clz_count;
    end
  end

`ifdef CLZ_ARBITER_STATS_EN
  // Saturating count of cycles where a result waits on the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall <= '0;
    end else if (rsp_valid && !rsp_ready && stat_stall != 16'hFFFF) begin
      stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clz_arbiter.sv
// Directed bench for clz_arbiter (NREQ=4, BITS_IN=32): table vectors for the
// count function plus sequences for round-robin, back-pressure and reset.
module tb_clz_arbiter;

  localparam int NREQ    = 4;
  localparam int BITS_IN = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*BITS_IN-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  logic [4:0]              rsp_count;
  logic                    rsp_zero;
`ifdef CLZ_ARBITER_STATS_EN
  logic [15:0]             stat_stall;
`endif

  int errors = 0;
  int checks = 0;

  clz_arbiter #(.NREQ(NREQ), .BITS_IN(BITS_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_zero  (rsp_zero)
`ifdef CLZ_ARBITER_STATS_EN
    ,
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cnt;
    logic        zero;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < NREQ; i++)
      req_data[i*BITS_IN +: BITS_IN] = 32'h8000_0000 >> (i + 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    vecs[0] = '{2, 32'h0001_0000, 15, 1'b0};
    vecs[1] = '{0, 32'h0000_0000,  0, 1'b1};
    vecs[2] = '{1, 32'h8000_0000,  0, 1'b0};
    vecs[3] = '{3, 32'h0000_0001, 31, 1'b0};
    vecs[4] = '{2, 32'hFFFF_FFFF,  0, 1'b0};
    vecs[5] = '{1, 32'h0000_00F0, 24, 1'b0};

    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests offered while reset is held.
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id",    32'(rsp_id),    32'h0);
    check("rst_rsp_count", 32'(rsp_count), 32'h0);
    check("rst_rsp_zero",  32'(rsp_zero),  32'h0);
`ifdef CLZ_ARBITER_STATS_EN
    check("rst_stat_stall", 32'(stat_stall), 32'h0);
`endif
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Table vectors: one requester at a time, result two edges later.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      req_valid = 4'(1 << vecs[v].id);
      req_data[vecs[v].id*BITS_IN +: BITS_IN] = vecs[v].data;
      #1;
      check($sformatf("v%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].id));
      @(negedge clk);
      req_valid = '0;
      #1;
      check($sformatf("v%0d_not_yet", v), 32'(rsp_valid), 32'h0);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_valid", v), 32'(rsp_valid), 32'h1);
      check($sformatf("v%0d_id", v),    32'(rsp_id),    32'(vecs[v].id));
      check($sformatf("v%0d_count", v), 32'(rsp_count), 32'(vecs[v].cnt));
      check($sformatf("v%0d_zero", v),  32'(rsp_zero),  32'(vecs[v].zero));
    end

    // Round-robin with all four requesters held from reset.
    @(negedge clk);
    do_reset();
    load_all();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      check($sformatf("rr%0d_grant", cyc), 32'(req_ready), 32'(1 << (cyc % 4)));
      if (cyc >= 2) begin
        check($sformatf("rr%0d_valid", cyc), 32'(rsp_valid), 32'h1);
        check($sformatf("rr%0d_id", cyc),    32'(rsp_id),    32'((cyc - 2) % 4));
        check($sformatf("rr%0d_count", cyc), 32'(rsp_count), 32'((cyc - 2) % 4 + 4));
      end
      @(negedge clk);
    end

    // Back-pressure: consumer stalled for five cycles.
    do_reset();
    rsp_ready = 1'b0;
    accepted = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      accepted += $countones(req_valid & req_ready);
      if (cyc >= 2) begin
        check($sformatf("bp%0d_ready", cyc), 32'(req_ready), 32'h0);
        check($sformatf("bp%0d_valid", cyc), 32'(rsp_valid), 32'h1);
        check($sformatf("bp%0d_id", cyc),    32'(rsp_id),    32'h0);
        check($sformatf("bp%0d_count", cyc), 32'(rsp_count), 32'h4);
`ifdef CLZ_ARBITER_STATS_EN
        check($sformatf("bp%0d_stall", cyc), 32'(stat_stall), 32'(cyc - 2));
`endif
      end
      @(negedge clk);
    end
    check("bp_accepted", 32'(accepted), 32'h2);

    // Release: results drain in order, refill in the same cycle.
    rsp_ready = 1'b1;
    #1;
    check("drain0_id",    32'(rsp_id),    32'h0);
    check("drain0_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    #1;
    check("drain1_valid", 32'(rsp_valid), 32'h1);
    check("drain1_id",    32'(rsp_id),    32'h1);
    check("drain1_count", 32'(rsp_count), 32'h5);
    check("drain1_grant", 32'(req_ready), 32'h8);
    rsp_ready = 1'b0;

    // Reset mid-operation with S1 and S2 full.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_valid_drop", 32'(rsp_valid), 32'h0);
    check("mrst_ready",      32'(req_ready), 32'h0);
`ifdef CLZ_ARBITER_STATS_EN
    check("mrst_stall",      32'(stat_stall), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("mrst_first_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    #1;
    check("mrst_no_stale", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    check("mrst_rsp_valid", 32'(rsp_valid), 32'h1);
    check("mrst_rsp_id",    32'(rsp_id),    32'h0);
    check("mrst_rsp_count", 32'(rsp_count), 32'h4);

    req_valid = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
